// File: rtl/lcd_line_builder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_line_builder
// Brief    : Renders the factory status and a binary item count (via a
//            sequential double-dabble engine) into two 16-char LCD lines.
//            Option macro: LCD_LINE_BUILDER_ZERO_BLANK_EN (blank leading zeros)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_line_builder #(
   parameter int COUNT_W = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
   input  logic [1:0]         STATUS,
   input  logic [COUNT_W-1:0] ITEM_COUNT,
   output logic               BUSY,
   output logic               DONE,
   output logic [127:0]       LINE_1,
   output logic [127:0]       LINE_2
);

   localparam int                c_iter_w    = $clog2(COUNT_W + 1);
   localparam logic [c_iter_w-1:0] c_iter_last = c_iter_w'(COUNT_W);
   localparam logic [c_iter_w-1:0] c_iter_one  = c_iter_w'(1);

   localparam logic [127:0] c_txt_idle  = {"SMART FACTORY", {3{8'h20}}};
   localparam logic [127:0] c_txt_run   = {"STATUS: RUN",   {5{8'h20}}};
   localparam logic [127:0] c_txt_stop  = {"STATUS: STOP",  {4{8'h20}}};
   localparam logic [127:0] c_txt_alarm = {"STATUS: ALARM", {3{8'h20}}};
   localparam logic [127:0] c_txt_reset = {"COUNT: -----",  {4{8'h20}}};
   localparam logic [55:0]  c_txt_count = "COUNT: ";
   localparam logic [31:0]  c_txt_pad   = {4{8'h20}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CONV     = 2'd1,
      ASSEMBLE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_stat;
   logic [COUNT_W-1:0]   r_bin;
   logic [19:0]          r_bcd;
   logic [c_iter_w-1:0]  r_iter;
   logic                 r_pending;
   logic                 r_done;
   logic [127:0]         r_line_1;
   logic [127:0]         r_line_2;

   logic                 w_load;
   logic                 w_shift;
   logic                 w_assemble;
   logic                 w_pending_nxt;
   logic [19:0]          w_bcd_adj;
   logic [39:0]          w_digits;
   logic [127:0]         w_line_1;
   logic [127:0]         w_line_2;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_shift       = 1'b0;
      w_assemble    = 1'b0;
      w_pending_nxt = r_pending;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_load      = 1'b1;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            if (START) begin
               w_pending_nxt = 1'b1;
            end
            if (r_iter == c_iter_last) begin
               w_state_nxt = ASSEMBLE;
            end else begin
               w_shift = 1'b1;
            end
         end
         ASSEMBLE: begin
            w_assemble    = 1'b1;
            w_pending_nxt = 1'b0;
            // A queued or simultaneous request re-samples the live inputs now
            if (r_pending || START) begin
               w_load      = 1'b1;
               w_state_nxt = CONV;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < 5; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

`ifdef LCD_LINE_BUILDER_ZERO_BLANK_EN
   logic w_lead;

   always_comb begin
      w_digits = '0;
      w_lead   = 1'b1;
      for (int i = 4; i >= 0; i--) begin
         if (w_lead && (r_bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
            w_digits[8*i +: 8] = 8'h20;
         end else begin
            w_lead             = 1'b0;
            w_digits[8*i +: 8] = {4'h3, r_bcd[4*i +: 4]};
         end
      end
   end
`else
   always_comb begin
      w_digits = '0;
      for (int i = 0; i < 5; i++) begin
         w_digits[8*i +: 8] = {4'h3, r_bcd[4*i +: 4]};
      end
   end
`endif

   always_comb begin
      w_line_1 = c_txt_idle;
      case (r_stat)
         2'd1:    w_line_1 = c_txt_run;
         2'd2:    w_line_1 = c_txt_stop;
         2'd3:    w_line_1 = c_txt_alarm;
         default: w_line_1 = c_txt_idle;
      endcase
      w_line_2 = {c_txt_count, w_digits, c_txt_pad};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_stat    <= 2'd0;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_iter    <= '0;
         r_pending <= 1'b0;
         r_done    <= 1'b0;
         r_line_1  <= c_txt_idle;
         r_line_2  <= c_txt_reset;
      end else begin
         r_pending <= w_pending_nxt;
         r_done    <= w_assemble;
         if (w_assemble) begin
            r_line_1 <= w_line_1;
            r_line_2 <= w_line_2;
         end
         if (w_load) begin
            r_stat <= STATUS;
            r_bin  <= ITEM_COUNT;
            r_bcd  <= '0;
            r_iter <= '0;
         end else if (w_shift) begin
            r_bcd  <= (w_bcd_adj << 1) | {19'd0, r_bin[COUNT_W-1]};
            r_bin  <= r_bin << 1;
            r_iter <= r_iter + c_iter_one;
         end
      end
   end

   assign BUSY   = (r_state != IDLE);
   assign DONE   = r_done;
   assign LINE_1 = r_line_1;
   assign LINE_2 = r_line_2;

endmodule
`default_nettype wire

// File: tb/tb_lcd_line_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_line_builder
// Brief    : Directed scoreboard bench for lcd_line_builder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_line_builder;

   logic         CLK;
   logic         RESET;
   logic         START;
   logic [1:0]   STATUS;
   logic [15:0]  ITEM_COUNT;
   logic         BUSY;
   logic         DONE;
   logic [127:0] LINE_1;
   logic [127:0] LINE_2;

   typedef struct {
      logic [127:0] l1;
      logic [127:0] l2;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests     = 0;
   int   fails     = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   done_cyc  = 0;
   int   done_prev = 0;
   int   t0;
   int   n0;
   int   busy_drops;

`ifdef LCD_LINE_BUILDER_ZERO_BLANK_EN
   localparam bit ZB = 1'b1;
`else
   localparam bit ZB = 1'b0;
`endif

   localparam logic [127:0] TXT_IDLE  = {"SMART FACTORY", {3{8'h20}}};
   localparam logic [127:0] TXT_RESET = {"COUNT: -----",  {4{8'h20}}};

   lcd_line_builder #(.COUNT_W(16)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .START      (START),
      .STATUS     (STATUS),
      .ITEM_COUNT (ITEM_COUNT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .LINE_1     (LINE_1),
      .LINE_2     (LINE_2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [127:0] exp_l1(input logic [1:0] s);
      case (s)
         2'd1:    return {"STATUS: RUN",   {5{8'h20}}};
         2'd2:    return {"STATUS: STOP",  {4{8'h20}}};
         2'd3:    return {"STATUS: ALARM", {3{8'h20}}};
         default: return {"SMART FACTORY", {3{8'h20}}};
      endcase
   endfunction

   function automatic logic [127:0] exp_l2(input int unsigned v);
      logic [127:0] l;
      int unsigned  dv;
      int unsigned  d;
      bit           lead;
      l          = {16{8'h20}};
      l[127:72]  = "COUNT: ";
      dv         = 10000;
      lead       = 1'b1;
      for (int p = 7; p < 12; p++) begin
         d = (v / dv) % 10;
         if (ZB && lead && d == 0 && p != 11) begin
            l[127-8*p -: 8] = 8'h20;
         end else begin
            lead            = 1'b0;
            l[127-8*p -: 8] = 8'h30 + 8'(d);
         end
         dv = dv / 10;
      end
      return l;
   endfunction

   task automatic check_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] s, input int unsigned v);
      exp_t e;
      e.l1 = exp_l1(s);
      e.l2 = exp_l2(v);
      sb.push_back(e);
   endtask

   // Returns at the falling edge right after the START-sampling edge.
   task automatic do_start(input logic [1:0] s, input logic [15:0] v, output int ts);
      @(negedge CLK);
      STATUS     = s;
      ITEM_COUNT = v;
      START      = 1'b1;
      @(negedge CLK);
      ts    = cyc;
      START = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int ts, input int nb);
      int k;
      k = 0;
      while (done_cnt == nb && k < 40) begin
         @(negedge CLK);
         #1;
         k++;
      end
      check_int({tag, "_done_seen"}, done_cnt - nb, 1);
      check_int({tag, "_latency"}, done_cyc - ts, 18);
   endtask

   task automatic run_conv(input string tag, input logic [1:0] s, input logic [15:0] v);
      int ts;
      int nb;
      nb = done_cnt;
      push_exp(s, v);
      do_start(s, v, ts);
      wait_done(tag, ts, nb);
      @(negedge CLK);
      #1;
      check_int({tag, "_done_pulse"}, int'(DONE), 0);
      check_int({tag, "_busy_after"}, int'(BUSY), 0);
   endtask

   // Scoreboard consumer: every DONE must match the oldest expected pair.
   always @(negedge CLK) begin
      if (DONE) begin
         done_prev = done_cyc;
         done_cyc  = cyc;
         done_cnt++;
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_done: got DONE=1 expected DONE=0 (no pending result)");
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_line("line_1", LINE_1, mon_e.l1);
            check_line("line_2", LINE_2, mon_e.l2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET      = 1'b1;
      START      = 1'b0;
      STATUS     = 2'd0;
      ITEM_COUNT = 16'd0;
      repeat (3) @(negedge CLK);
      check_line("rst_line_1", LINE_1, TXT_IDLE);
      check_line("rst_line_2", LINE_2, TXT_RESET);
      check_int("rst_busy", int'(BUSY), 0);
      check_int("rst_done", int'(DONE), 0);
      RESET = 1'b0;
      repeat (100) @(negedge CLK);
      #1;
      check_int("idle_no_done", done_cnt, 0);
      check_line("idle_line_2", LINE_2, TXT_RESET);

      run_conv("single", 2'd1, 16'd12345);
      repeat (5) @(negedge CLK);
      check_line("hold_line_2", LINE_2, exp_l2(12345));

      run_conv("zero", 2'd0, 16'd0);
      run_conv("max", 2'd2, 16'd65535);
      run_conv("small", 2'd3, 16'd42);

      // Pending chaining: extra STARTs collapse, inputs taken at chain start
      n0 = done_cnt;
      push_exp(2'd1, 100);
      push_exp(2'd1, 300);
      do_start(2'd1, 16'd100, t0);
      busy_drops = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (k == 4 || k == 8) begin
            START      = 1'b1;
            ITEM_COUNT = 16'd200;
         end
         if (k == 5 || k == 9) START = 1'b0;
         if (k == 16) ITEM_COUNT = 16'd300;
         if (k <= 35 && !BUSY) busy_drops++;
      end
      #1;
      check_int("chain_done_count", done_cnt - n0, 2);
      check_int("chain_first_latency", done_prev - t0, 18);
      check_int("chain_spacing", done_cyc - done_prev, 18);
      check_int("chain_busy_drops", busy_drops, 0);

      // Input churn while busy
      n0 = done_cnt;
      push_exp(2'd3, 7);
      do_start(2'd3, 16'd7, t0);
      for (int k = 0; k < 40 && done_cnt == n0; k++) begin
         STATUS     = 2'($urandom);
         ITEM_COUNT = 16'($urandom);
         @(negedge CLK);
         #1;
      end
      check_int("churn_done_seen", done_cnt - n0, 1);
      check_int("churn_latency", done_cyc - t0, 18);
      @(negedge CLK);

      // Reset mid-conversion with a pending request queued
      n0 = done_cnt;
      do_start(2'd0, 16'd999, t0);
      repeat (2) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      #1;
      RESET = 1'b1;
      #1;
      check_line("abort_line_1", LINE_1, TXT_IDLE);
      check_line("abort_line_2", LINE_2, TXT_RESET);
      check_int("abort_busy", int'(BUSY), 0);
      check_int("abort_done", int'(DONE), 0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (30) @(negedge CLK);
      #1;
      check_int("abort_no_done", done_cnt - n0, 0);
      run_conv("after_abort", 2'd2, 16'd54321);
      repeat (30) @(negedge CLK);
      #1;
      check_int("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
